// File: rtl/snoop_responder.sv
// snoop_responder: bus-side MESI snoop controller for one node's two-line
// direct-mapped cache. Looks up snooped tags, flushes Modified data to memory,
// and downgrades or invalidates the line.
module snoop_responder (
  input  logic        clock,
  input  logic        clear,
  input  logic        bus_valid,
  input  logic [4:0]  bus_in,
  output logic [4:0]  bus_out,
  output logic        snp_busy,
  output logic        snp_done,
  output logic        snp_hit,
  output logic        snp_err,
  output logic        mem_we,
  output logic [2:0]  mem_tag,
  output logic [2:0]  mem_data,
  input  logic        mem_ack,
  input  logic        loc_we,
  input  logic        loc_idx,
  input  logic [7:0]  loc_line,
  output logic        loc_ack,
  output logic [15:0] lines_out
);

  localparam int unsigned ST_W   = 2;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DATA_W = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned BUS_W  = 5;

  localparam logic [ST_W-1:0] MESI_I = 2'b00;
  localparam logic [ST_W-1:0] MESI_S = 2'b01;
  localparam logic [ST_W-1:0] MESI_E = 2'b10;
  localparam logic [ST_W-1:0] MESI_M = 2'b11;

  localparam logic [OP_W-1:0] OP_NONE = 2'b00;
  localparam logic [OP_W-1:0] OP_RD   = 2'b01;
  localparam logic [OP_W-1:0] OP_WR   = 2'b10;
  localparam logic [OP_W-1:0] OP_INV  = 2'b11;

  typedef struct packed {
    logic [ST_W-1:0]   st;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  line_t [1:0]       lines_q, lines_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic [ST_W-1:0]   nst_q, nst_d;
  logic [BUS_W-1:0]  bus_out_d;
  logic              snp_done_d, snp_hit_d, snp_err_d;
  logic              mem_we_d;
  logic [TAG_W-1:0]  mem_tag_d;
  logic [DATA_W-1:0] mem_data_d;

  line_t cur_line;
  logic  hit_c, flush_c, capture_c;

  // Lookup of the latched tag against its indexed line
  always_comb begin
    cur_line  = lines_q[tag_q[0]];
    hit_c     = (cur_line.tag == tag_q) && (cur_line.st != MESI_I);
    flush_c   = hit_c && (cur_line.st == MESI_M) && ((op_q == OP_RD) || (op_q == OP_WR));
    capture_c = bus_valid && (bus_in[4:3] != OP_NONE);
  end

  assign snp_busy  = (state_q != IDLE);
  assign loc_ack   = loc_we && (state_q == IDLE);
  assign lines_out = lines_q;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_c) state_d = LOOKUP;
      LOOKUP:  state_d = flush_c ? FLUSH : DONE;
      FLUSH:   if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, array and transaction context
  always_comb begin
    lines_d    = lines_q;
    op_d       = op_q;
    tag_d      = tag_q;
    hit_d      = hit_q;
    err_d      = err_q;
    nst_d      = nst_q;
    bus_out_d  = bus_out;
    mem_we_d   = mem_we;
    mem_tag_d  = mem_tag;
    mem_data_d = mem_data;
    snp_done_d = 1'b0;
    snp_hit_d  = 1'b0;
    snp_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (loc_we) lines_d[loc_idx] = line_t'(loc_line);
        if (capture_c) begin
          op_d  = bus_in[4:3];
          tag_d = bus_in[2:0];
        end
      end
      LOOKUP: begin
        hit_d = hit_c;
        err_d = 1'b0;
        nst_d = cur_line.st;
        if (hit_c) begin
          case (op_q)
            OP_RD:   nst_d = MESI_S;
            OP_WR:   nst_d = MESI_I;
            OP_INV: begin
              if (cur_line.st == MESI_S) nst_d = MESI_I;
              else err_d = (cur_line.st == MESI_E) || (cur_line.st == MESI_M);
            end
            default: nst_d = cur_line.st;
          endcase
        end
        bus_out_d  = {hit_c, flush_c, flush_c ? cur_line.data : DATA_W'(0)};
        mem_we_d   = flush_c;
        mem_tag_d  = flush_c ? cur_line.tag  : TAG_W'(0);
        mem_data_d = flush_c ? cur_line.data : DATA_W'(0);
      end
      FLUSH: begin
        if (mem_ack) begin
          mem_we_d   = 1'b0;
          mem_tag_d  = TAG_W'(0);
          mem_data_d = DATA_W'(0);
        end
      end
      DONE: begin
        if (hit_q) lines_d[tag_q[0]].st = nst_q;
        snp_done_d = 1'b1;
        snp_hit_d  = hit_q;
        snp_err_d  = err_q;
        bus_out_d  = BUS_W'(0);
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any transaction in flight
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      lines_q  <= '0;
      op_q     <= OP_NONE;
      tag_q    <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
      nst_q    <= MESI_I;
      bus_out  <= '0;
      mem_we   <= 1'b0;
      mem_tag  <= '0;
      mem_data <= '0;
      snp_done <= 1'b0;
      snp_hit  <= 1'b0;
      snp_err  <= 1'b0;
    end else begin
      lines_q  <= lines_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
      nst_q    <= nst_d;
      bus_out  <= bus_out_d;
      mem_we   <= mem_we_d;
      mem_tag  <= mem_tag_d;
      mem_data <= mem_data_d;
      snp_done <= snp_done_d;
      snp_hit  <= snp_hit_d;
      snp_err  <= snp_err_d;
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with hand-computed expected values.
module tb_snoop_responder;

  logic        clock, clear;
  logic        bus_valid;
  logic [4:0]  bus_in;
  logic [4:0]  bus_out;
  logic        snp_busy, snp_done, snp_hit, snp_err;
  logic        mem_we;
  logic [2:0]  mem_tag, mem_data;
  logic        mem_ack;
  logic        loc_we, loc_idx;
  logic [7:0]  loc_line;
  logic        loc_ack;
  logic [15:0] lines_out;

  int n_checks = 0;
  int n_fail   = 0;

  snoop_responder dut (
    .clock(clock), .clear(clear), .bus_valid(bus_valid), .bus_in(bus_in),
    .bus_out(bus_out), .snp_busy(snp_busy), .snp_done(snp_done),
    .snp_hit(snp_hit), .snp_err(snp_err), .mem_we(mem_we),
    .mem_tag(mem_tag), .mem_data(mem_data), .mem_ack(mem_ack),
    .loc_we(loc_we), .loc_idx(loc_idx), .loc_line(loc_line),
    .loc_ack(loc_ack), .lines_out(lines_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present a bus message so that the next edge captures it
  task automatic capture(input logic [1:0] op, input logic [2:0] tag);
    bus_valid = 1'b1;
    bus_in    = {op, tag};
    cyc();
    bus_valid = 1'b0;
    bus_in    = 5'b0;
  endtask

  // Local line write in IDLE
  task automatic loc_write(input logic idx, input logic [7:0] line);
    loc_we = 1'b1; loc_idx = idx; loc_line = line;
    #1;
    check_eq("loc_ack_idle", 32'(loc_ack), 32'd1);
    cyc();
    loc_we = 1'b0;
  endtask

  initial begin
    clear = 1'b0; bus_valid = 1'b0; bus_in = 5'b0; mem_ack = 1'b0;
    loc_we = 1'b0; loc_idx = 1'b0; loc_line = 8'h00;
    #12;
    check_eq("rst_lines", 32'(lines_out), 32'h0000);
    check_eq("rst_bus_out", 32'(bus_out), 32'h0);
    check_eq("rst_busy", 32'(snp_busy), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_done", 32'(snp_done), 32'd0);
    clear = 1'b1;
    cyc();

    // op=00 is ignored
    bus_valid = 1'b1; bus_in = 5'b00_101;
    cyc();
    bus_valid = 1'b0;
    check_eq("nop_busy", 32'(snp_busy), 32'd0);

    // Read miss on empty cache
    capture(2'b01, 3'b101);
    check_eq("t1_busy", 32'(snp_busy), 32'd1);
    cyc();
    check_eq("t1_shared", 32'(bus_out), 32'h0);
    check_eq("t1_mem_we", 32'(mem_we), 32'd0);
    check_eq("t1_done_early", 32'(snp_done), 32'd0);
    cyc();
    check_eq("t1_done", 32'(snp_done), 32'd1);
    check_eq("t1_hit", 32'(snp_hit), 32'd0);
    check_eq("t1_busy_end", 32'(snp_busy), 32'd0);
    check_eq("t1_lines", 32'(lines_out), 32'h0000);
    cyc();
    check_eq("t1_done_pulse", 32'(snp_done), 32'd0);

    // E line, read miss hit -> S, no flush
    loc_write(1'b1, 8'b10_101_110);
    check_eq("t2_lines_wr", 32'(lines_out), 32'hAE00);
    capture(2'b01, 3'b101);
    cyc();
    check_eq("t2_shared", 32'(bus_out), 32'h10);
    check_eq("t2_mem_we", 32'(mem_we), 32'd0);
    cyc();
    check_eq("t2_done", 32'(snp_done), 32'd1);
    check_eq("t2_hit", 32'(snp_hit), 32'd1);
    check_eq("t2_err", 32'(snp_err), 32'd0);
    check_eq("t2_lines", 32'(lines_out), 32'h6E00);

    // M line, write miss hit with mem_ack delayed two cycles
    loc_write(1'b0, 8'b11_010_011);
    capture(2'b10, 3'b010);
    cyc();
    check_eq("t3_mem_we1", 32'(mem_we), 32'd1);
    check_eq("t3_mem_tag", 32'(mem_tag), 32'h2);
    check_eq("t3_mem_data", 32'(mem_data), 32'h3);
    check_eq("t3_bus_out1", 32'(bus_out), 32'h1B);
    cyc();
    check_eq("t3_mem_we2", 32'(mem_we), 32'd1);
    check_eq("t3_bus_out2", 32'(bus_out), 32'h1B);
    check_eq("t3_lines_hold", 32'(lines_out), 32'h6ED3);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check_eq("t3_mem_we_drop", 32'(mem_we), 32'd0);
    check_eq("t3_not_done", 32'(snp_done), 32'd0);
    cyc();
    check_eq("t3_done", 32'(snp_done), 32'd1);
    check_eq("t3_hit", 32'(snp_hit), 32'd1);
    check_eq("t3_bus_clr", 32'(bus_out), 32'h0);
    check_eq("t3_lines", 32'(lines_out), 32'h6E13);

    // Invalidate on S line -> I
    loc_write(1'b1, 8'b01_111_010);
    capture(2'b11, 3'b111);
    cyc(); cyc();
    check_eq("t4_done", 32'(snp_done), 32'd1);
    check_eq("t4_hit", 32'(snp_hit), 32'd1);
    check_eq("t4_err", 32'(snp_err), 32'd0);
    check_eq("t4_lines", 32'(lines_out), 32'h3A13);

    // Invalidate on M line -> unchanged, error
    loc_write(1'b0, 8'b11_010_011);
    capture(2'b11, 3'b010);
    cyc();
    check_eq("t5_shared", 32'(bus_out), 32'h10);
    check_eq("t5_mem_we", 32'(mem_we), 32'd0);
    cyc();
    check_eq("t5_hit", 32'(snp_hit), 32'd1);
    check_eq("t5_err", 32'(snp_err), 32'd1);
    check_eq("t5_lines", 32'(lines_out), 32'h3AD3);
    cyc();
    check_eq("t5_err_pulse", 32'(snp_err), 32'd0);

    // Local write while busy is refused
    capture(2'b01, 3'b000);
    loc_we = 1'b1; loc_idx = 1'b0; loc_line = 8'hFF;
    #1;
    check_eq("t6_ack_lookup", 32'(loc_ack), 32'd0);
    cyc();
    check_eq("t6_ack_done", 32'(loc_ack), 32'd0);
    loc_we = 1'b0;
    cyc();
    check_eq("t6_miss", 32'(snp_hit), 32'd0);
    check_eq("t6_lines", 32'(lines_out), 32'h3AD3);

    // Local write and bus capture on the same edge, same index
    loc_we = 1'b1; loc_idx = 1'b1; loc_line = 8'b10_111_001;
    bus_valid = 1'b1; bus_in = 5'b01_111;
    #1;
    check_eq("t7_ack", 32'(loc_ack), 32'd1);
    cyc();
    loc_we = 1'b0; bus_valid = 1'b0; bus_in = 5'b0;
    cyc();
    check_eq("t7_shared", 32'(bus_out), 32'h10);
    cyc();
    check_eq("t7_hit", 32'(snp_hit), 32'd1);
    check_eq("t7_lines", 32'(lines_out), 32'h79D3);

    // Reset asserted during FLUSH aborts
    capture(2'b01, 3'b010);
    cyc();
    check_eq("t8_mem_we", 32'(mem_we), 32'd1);
    #2 clear = 1'b0;
    #1;
    check_eq("t8_mem_we_rst", 32'(mem_we), 32'd0);
    check_eq("t8_busy_rst", 32'(snp_busy), 32'd0);
    check_eq("t8_lines_rst", 32'(lines_out), 32'h0000);
    check_eq("t8_bus_rst", 32'(bus_out), 32'h0);
    #1 clear = 1'b1;
    cyc();
    check_eq("t8_idle_after", 32'(snp_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
# snoop_responder

Bus-side snoop controller for one CPU node of the MESI cache system. It owns the node's two-line direct-mapped cache array and watches messages other nodes place on the shared bus. On a hit it reports sharing, flushes Modified data to memory and downgrades or invalidates the line. It is the responder end of the protocol whose initiator is the node's CPU request engine, which reads and writes lines through the local port.

## Interface
Parameters:
- None. Widths are fixed by the line format: line = {state[7:6], tag[5:3], data[2:0]}. State encoding: 00 I, 01 S, 10 E, 11 M. Index = tag[0].

Ports:
- clock  in  1  single clock; all state changes on rising edge
- clear  in  1  reset, asynchronous, active-low
- bus_valid  in  1  bus message present this cycle
- bus_in  in  5  {op[4:3], tag[2:0]}; op 00 none, 01 read miss, 10 write miss, 11 invalidate
- bus_out  out  5  registered {shared, flush, data[2:0]}
- snp_busy  out  1  FSM not in IDLE
- snp_done  out  1  one-cycle pulse, transaction finished
- snp_hit  out  1  valid with snp_done: tag matched and state != I
- snp_err  out  1  one-cycle pulse with snp_done: invalidate hit an E/M line
- mem_we  out  1  write-back request
- mem_tag  out  3  write-back tag
- mem_data  out  3  write-back data
- mem_ack  in  1  memory accepted write-back
- loc_we  in  1  local line write request
- loc_idx  in  1  local line index
- loc_line  in  8  local line value
- loc_ack  out  1  combinational: loc_we && FSM in IDLE
- lines_out  out  16  {line1, line0}, continuously driven from the array

## Operation
- FSM states: IDLE, LOOKUP, FLUSH, DONE.
- IDLE: at an edge with bus_valid=1 and op!=00, latch op and tag, then go to LOOKUP. op=00 is ignored.
- LOOKUP: read line[tag[0]]. hit = (line.tag==tag) && (line.state!=I). Register bus_out.shared=hit.
  - hit && state M && op in {read miss, write miss}: go to FLUSH.
  - Otherwise go to DONE.
- FLUSH: mem_we=1, mem_tag=line.tag, mem_data=line.data. bus_out.flush=1, bus_out.data=line.data. Hold all of these until mem_ack=1 is sampled, then go to DONE.
- DONE: write the next state into the line (tag and data unchanged). Pulse snp_done with snp_hit and snp_err, clear bus_out to 0, go to IDLE.
- Next state on hit:
  - read miss: M→S, E→S, S→S.
  - write miss: M/E/S→I.
  - invalidate: S→I. E or M are left unchanged and snp_err=1.
- Miss: no line change, snp_hit=0.
- Local port: writes are accepted only in IDLE, and the full 8-bit line is written. In any other state loc_we is ignored and loc_ack=0, so the requester must retry.
- loc_we and a bus capture on the same IDLE edge: both take effect. The LOOKUP then sees the newly written line.
- bus_valid outside IDLE is ignored. The bus arbiter guarantees one outstanding message per node.

## Timing
- Reset (clear low, asynchronous):
  - lines = 8'h00 (all I).
  - FSM = IDLE.
  - bus_out, snp_done, snp_hit, snp_err, mem_we, mem_tag, mem_data = 0.
- Reset mid-transaction aborts immediately. mem_we drops without waiting for mem_ack, and the line is not updated.
- Edge E0 captures the message. snp_busy=1 after E0.
- E1 evaluates LOOKUP; bus_out.shared is valid after E1.
- Non-flush path: E2 executes DONE. snp_done is high in the cycle after E2 and snp_busy=0. The next message can be captured at E3. Capture-to-done latency is 3 cycles.
- Flush path: mem_we is high from after E1 until the edge that samples mem_ack=1. DONE executes at the following edge. Latency is 3 + N cycles, where N is the number of FLUSH cycles (N≥1 when mem_ack is already high).
- mem_ack outside FLUSH is ignored.

## Test plan
- Reset, then read miss tag 3'b101: snp_hit=0, shared=0, no mem_we, lines_out=16'h0000, snp_done 3 cycles after capture.
- Local write idx1 line 8'b10_101_110 (E), then read miss tag 101: shared=1, snp_hit=1, line1→8'b01_101_110, no flush.
- Local write idx0 8'b11_010_011 (M), then write miss tag 010 with mem_ack delayed 2 cycles:
  - mem_we=1, mem_tag=010, mem_data=011, bus_out=5'b11011 for 2 cycles.
  - Then line0→8'b00_010_011 and snp_done.
- Line1 in S, invalidate tag 111 → line1 state I. Line0 in M, invalidate matching tag → line unchanged, snp_err=1, snp_hit=1.
- loc_we during LOOKUP → loc_ack=0, array unchanged. Then loc_we and bus_valid on the same IDLE edge for the same index → LOOKUP uses the new line.
- Assert clear low during FLUSH → mem_we=0 asynchronously, FSM IDLE, all lines 8'h00.
